// File: rtl/jk_cmd_seq.sv
// ============================================================================
// jk_cmd_seq
// ----------------------------------------------------------------------------
// Queues JK-opcode commands and plays each one onto registered J/K drive
// lines for (count + 1) cycles. The lines feed a downstream JK flip-flop.
// Commands run back-to-back with no HOLD gap while the queue holds work.
//
// Parameters
//   DEPTH   command FIFO entries (power of two, >= 2)
//   CNT_W   width of the per-command repeat count
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   in_valid  in   command offered
//   in_op     in   [1:0] opcode: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   in_cnt    in   [CNT_W-1:0] repeat count (drive for in_cnt+1 cycles)
//   in_ready  out  FIFO can accept a command (!full && !abort)
//   abort     in   flush the queue and the command in flight
//   j, k      out  registered J/K drive
//   busy      out  a command is executing or the FIFO is non-empty
//   cmd_done  out  pulse on the final drive cycle of each command
//
// Optional feature (macro JK_SEQ_QMODEL_EN)
//   q_fb      in   downstream flip-flop output
//   q_err     out  sticky flag: q_fb disagreed with the internal Q model
// ============================================================================
module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic [CNT_W-1:0] in_cnt,
    output logic             in_ready,
    input  logic             abort,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             cmd_done
`ifdef JK_SEQ_QMODEL_EN
    ,
    input  logic             q_fb,
    output logic             q_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 2 + CNT_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO: pointers carry one extra wrap bit for full/empty.
    // ------------------------------------------------------------------
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty, full;
    logic             push, pop;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_cnt;

    state_t           state_q;
    logic [CNT_W-1:0] remain_q;
    logic             j_q, k_q, done_q;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full && !abort;
    assign push     = in_valid && in_ready;

    // The head is consumed when the sequencer is idle, or on the final
    // drive cycle of the current command (back-to-back issue).
    assign pop      = !abort && !empty &&
                      ((state_q == IDLE) || (remain_q == '0));

    assign {head_op, head_cnt} = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q[AW-1:0]] <= {in_op, in_cnt};
    end

    // ------------------------------------------------------------------
    // Issue FSM. cmd_done is registered, so it is raised on the edge that
    // makes remain reach zero (load of a zero count, or decrement from 1).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q  <= IDLE;
            remain_q <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        {j_q, k_q} <= head_op;
                        remain_q   <= head_cnt;
                        done_q     <= (head_cnt == '0);
                        state_q    <= ISSUE;
                    end else begin
                        {j_q, k_q} <= 2'b00;
                        done_q     <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (remain_q != '0) begin
                        remain_q <= remain_q - CNT_W'(1);
                        done_q   <= (remain_q == CNT_W'(1));
                    end else if (!empty) begin
                        {j_q, k_q} <= head_op;
                        remain_q   <= head_cnt;
                        done_q     <= (head_cnt == '0);
                    end else begin
                        {j_q, k_q} <= 2'b00;
                        done_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    {j_q, k_q} <= 2'b00;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign cmd_done = done_q;
    assign busy     = (state_q == ISSUE) || !empty;

`ifdef JK_SEQ_QMODEL_EN
    // ------------------------------------------------------------------
    // Shadow model of the downstream flip-flop, driven by the same J/K.
    // ------------------------------------------------------------------
    logic q_model_q;
    logic q_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_model_q <= 1'b0;
            q_err_q   <= 1'b0;
        end else begin
            case ({j_q, k_q})
                2'b01:   q_model_q <= 1'b0;
                2'b10:   q_model_q <= 1'b1;
                2'b11:   q_model_q <= ~q_model_q;
                default: q_model_q <= q_model_q;
            endcase
            if (abort)                   q_err_q <= 1'b0;
            else if (q_fb != q_model_q)  q_err_q <= 1'b1;
        end
    end

    assign q_err = q_err_q;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// ============================================================================
// tb_jk_cmd_seq
// ----------------------------------------------------------------------------
// Self-checking bench for jk_cmd_seq. Accepted commands are expanded into
// per-cycle expected J/K/cmd_done entries on a scoreboard queue; a monitor
// pops and compares them each cycle, along with busy and in_ready.
// Define JK_SEQ_QMODEL_EN to also exercise q_fb / q_err.
// ============================================================================
module tb_jk_cmd_seq;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [1:0]       in_op;
    logic [CNT_W-1:0] in_cnt;
    logic             in_ready;
    logic             abort;
    logic             j, k, busy, cmd_done;
`ifdef JK_SEQ_QMODEL_EN
    logic             q_fb, q_err, q_ff, inj;
`endif

    jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_cnt   (in_cnt),
        .in_ready (in_ready),
        .abort    (abort),
        .j        (j),
        .k        (k),
        .busy     (busy),
        .cmd_done (cmd_done)
`ifdef JK_SEQ_QMODEL_EN
        ,
        .q_fb     (q_fb),
        .q_err    (q_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] jk;
        logic       done;
        logic       first;
        int         elig;
    } item_t;

    item_t sb[$];
    int    cyc     = 0;
    int    pending = 0;
    int    passed  = 0;
    int    fails   = 0;
    int    total   = 0;
    bit    mon_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Acceptance bookkeeping: the bench decides from its own occupancy model
    // whether a command was taken, then expands it into drive cycles.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset || abort) begin
            sb.delete();
            pending = 0;
        end else if (in_valid && pending < DEPTH) begin
            for (int unsigned i = 0; i <= 32'(in_cnt); i++)
                sb.push_back('{jk: in_op, done: (i == 32'(in_cnt)),
                               first: (i == 0), elig: cyc + 1});
            pending++;
        end
    end

    // Per-cycle output comparison, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] exp_jk;
            logic       exp_done, exp_busy, exp_ready;
            item_t      it;
            exp_jk   = 2'b00;
            exp_done = 1'b0;
            exp_busy = (sb.size() != 0);
            if (sb.size() != 0 && sb[0].elig <= cyc) begin
                it       = sb.pop_front();
                exp_jk   = it.jk;
                exp_done = it.done;
                if (it.first) pending--;
            end
            exp_ready = !abort && (pending < DEPTH);
            check("jk",       {30'd0, j, k},      {30'd0, exp_jk});
            check("cmd_done", {31'd0, cmd_done},  {31'd0, exp_done});
            check("busy",     {31'd0, busy},      {31'd0, exp_busy});
            check("in_ready", {31'd0, in_ready},  {31'd0, exp_ready});
        end
    end

`ifdef JK_SEQ_QMODEL_EN
    always @(posedge clk) begin
        if (reset) q_ff <= 1'b0;
        else case ({j, k})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end
    assign q_fb = q_ff ^ inj;
`endif

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic step(input logic v, input logic [1:0] op,
                        input logic [CNT_W-1:0] cnt, input logic ab);
        in_valid = v;
        in_op    = op;
        in_cnt   = cnt;
        abort    = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            idle(1);
            n++;
        end
        check(tag, {31'd0, (sb.size() == 0)}, 32'd1);
        idle(2);
    endtask

    initial begin
        int acc;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_cnt   = '0;
        abort    = 1'b0;
`ifdef JK_SEQ_QMODEL_EN
        inj      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("reset_jk",    {30'd0, j, k}, 32'd0);
        check("reset_busy",  {31'd0, busy}, 32'd0);
        step(1'b0, 2'b00, '0, 1'b0);
        reset = 1'b0;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // SET for 4 cycles, then HOLD and idle.
        step(1'b1, 2'b10, 4'd3, 1'b0);
        idle(8);

        // Three back-to-back commands.
        step(1'b1, 2'b11, 4'd0, 1'b0);
        step(1'b1, 2'b01, 4'd1, 1'b0);
        step(1'b1, 2'b10, 4'd0, 1'b0);
        idle(6);

        // Maximum count: 16 drive cycles of SET.
        step(1'b1, 2'b10, 4'd15, 1'b0);
        drain("drain_max_cnt");

        // Fill the FIFO behind a long HOLD command.
        step(1'b1, 2'b00, 4'd15, 1'b0);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_op    = 2'(acc + 1);
            in_cnt   = 4'd1;
            #1;
            if (!in_ready) break;
            acc++;
            @(posedge clk);
            #1;
        end
        check("fill_accepts", acc, 32'd4);
        idle(1);
        drain("drain_fill");

        // Abort in the 2nd drive cycle with two entries queued, plus an
        // offered command in the abort cycle that must be dropped.
        step(1'b1, 2'b10, 4'd5, 1'b0);
        step(1'b1, 2'b11, 4'd1, 1'b0);
        step(1'b1, 2'b01, 4'd2, 1'b0);
        step(1'b1, 2'b11, 4'd3, 1'b1);
        check("abort_jk",   {30'd0, j, k}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        idle(4);

        // Reset mid-command with in_valid high.
        step(1'b1, 2'b11, 4'd7, 1'b0);
        idle(3);
        reset = 1'b1;
        step(1'b1, 2'b10, 4'd2, 1'b0);
        reset = 1'b0;
        check("midreset_jk",   {30'd0, j, k},        32'd0);
        check("midreset_done", {31'd0, cmd_done},    32'd0);
        idle(5);

`ifdef JK_SEQ_QMODEL_EN
        step(1'b1, 2'b11, 4'd2, 1'b0);
        idle(5);
        check("qerr_clean", {31'd0, q_err}, 32'd0);
        inj = 1'b1;
        step(1'b0, 2'b00, '0, 1'b0);
        inj = 1'b0;
        check("qerr_set", {31'd0, q_err}, 32'd1);
        idle(3);
        check("qerr_sticky", {31'd0, q_err}, 32'd1);
        step(1'b0, 2'b00, '0, 1'b1);
        check("qerr_abort_clr", {31'd0, q_err}, 32'd0);
        idle(2);
`endif

        check("sb_empty", {31'd0, (sb.size() == 0)}, 32'd1);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/jk_cmd_seq.md
JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 4, width of the per-command repeat count.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  command offered.
REQ-006 SHALL have port in_op  input  2  JK opcode: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
REQ-007 SHALL have port in_cnt  input  CNT_W  repeat count; the command is driven for in_cnt+1 cycles.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a command.
REQ-009 SHALL have port abort  input  1  discard the queued command and the command in flight.
REQ-010 SHALL have port j  output  1  registered J drive to the downstream JK flip-flop.
REQ-011 SHALL have port k  output  1  registered K drive to the downstream JK flip-flop.
REQ-012 SHALL have port busy  output  1  a command is executing or the FIFO is non-empty.
REQ-013 SHALL have port cmd_done  output  1  single-cycle pulse marking the final drive cycle of a command.

Function
REQ-014 SHALL accept a command on a rising edge where in_valid && in_ready; in_ready = !full && !abort.
REQ-015 SHALL store {in_op, in_cnt} in a DEPTH-entry FIFO with wrap-around pointers; a push on full is impossible by construction.
REQ-016 SHALL permit a push and a pop on the same edge when the FIFO is neither full nor empty, and also when it is empty and the pop is not taken.
REQ-017 SHALL implement an FSM with two states, IDLE and ISSUE.
REQ-018 In IDLE with the FIFO non-empty, it SHALL pop the head entry, load {j,k}=op and remain=cnt, and enter ISSUE on the same edge.
REQ-019 A command accepted at edge E into an empty FIFO while in IDLE SHALL appear on j,k after edge E+1.
REQ-020 In ISSUE with remain>0, it SHALL hold {j,k} and decrement remain each edge.
REQ-021 In ISSUE with remain==0, it SHALL assert cmd_done for that cycle.
REQ-022 In ISSUE with remain==0 and the FIFO non-empty, it SHALL pop the next command and load it with no HOLD gap (back-to-back).
REQ-023 In ISSUE with remain==0 and the FIFO empty, it SHALL drive {j,k}=00 and return to IDLE.
REQ-024 In IDLE, it SHALL drive {j,k}=00 (HOLD).
REQ-025 in_cnt all-ones SHALL give 2^CNT_W drive cycles; remain SHALL never wrap below zero.
REQ-026 abort SHALL empty the FIFO, force {j,k}=00 and IDLE on the next edge, and suppress cmd_done; a command offered in the same cycle is dropped.
REQ-027 busy SHALL be combinational: (state==ISSUE) || !empty.

Reset
REQ-028 While reset is high at an edge, it SHALL set j=0, k=0, cmd_done=0, state=IDLE, FIFO empty, and remain=0.
REQ-029 Reset SHALL override abort and in_valid; in_ready SHALL be 1 in the first cycle after reset is released.
REQ-030 Reset asserted mid-command SHALL discard that command without a cmd_done pulse.

Configuration
REQ-031 With macro JK_SEQ_QMODEL_EN defined, it SHALL add port q_fb (input, 1, downstream FF output) and port q_err (output, 1, sticky mismatch flag).
REQ-032 With JK_SEQ_QMODEL_EN defined, it SHALL keep an internal q_model that resets to 0 and updates each edge from the current {j,k} using HOLD/RESET/SET/TOGGLE semantics.
REQ-033 With JK_SEQ_QMODEL_EN defined, q_err SHALL be set on any edge where q_fb != q_model, and cleared by reset or abort.
REQ-034 Without JK_SEQ_QMODEL_EN, these ports and the model SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Reset released, push {10,3} at edge E -> j,k=10 after E+1 through E+4; cmd_done in the 4th drive cycle; j,k=00 after E+5; busy low afterward.
REQ-036 Push {11,0},{01,1},{10,0} consecutively -> j,k sequence 11,01,01,10,00 with no gaps; three cmd_done pulses.
REQ-037 Hold in_valid with DEPTH=4 while a {00,15} command executes -> in_ready low after 4 more accepts; no entry lost or duplicated; order preserved.
REQ-038 abort during the 2nd drive cycle of {10,5} with 2 entries queued -> j,k=00 next cycle; FIFO empty; no cmd_done; busy low.
REQ-039 Reset asserted mid-command with in_valid high -> all outputs 0; the command pushed in the reset cycle is not stored.
REQ-040 With JK_SEQ_QMODEL_EN, a bench FF model is fed j,k: TOGGLE x3 -> q_err stays 0; forcing q_fb inverted for one cycle -> q_err=1 and stays 1 until abort.
